// File: rtl/pe_stream_pkg.sv
// Shared types and constants for the PE stream driver.
// FSM state encoding and IFMap row-marker bit positions.
package pe_stream_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CFG       = 3'd1,
    LOAD_FILT = 3'd2,
    STREAM    = 3'd3,
    DRAIN     = 3'd4,
    DONE      = 3'd5
  } state_e;

  localparam int IFMAP_WIDTH_DEF = 18;
  localparam int SOR_BIT = IFMAP_WIDTH_DEF - 1;
  localparam int EOR_BIT = IFMAP_WIDTH_DEF - 2;

endpackage

// File: rtl/psum_skid_buf.sv
// Two-entry skid buffer for a one-cycle-latency Psum read port.
// Ports: en/psum_empty -> ren, Psum_out capture, m_data/m_valid/m_ready, idle.
module psum_skid_buf #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         psum_empty,
  output logic         ren,
  input  logic [W-1:0] Psum_out,
  output logic [W-1:0] m_data,
  output logic         m_valid,
  input  logic         m_ready,
  output logic         idle
);

  logic [W-1:0] e0;
  logic [W-1:0] e1;
  logic [1:0]   cnt;
  logic         inflight;
  logic         push;
  logic         pop;

  assign push    = inflight;
  assign m_valid = (cnt != 2'd0);
  assign pop     = m_valid & m_ready;
  assign m_data  = e0;
  assign idle    = (cnt == 2'd0) & ~inflight;

  // A read is only issued if its data is guaranteed a free slot.
  assign ren = en & ~psum_empty
             & (({1'b0, cnt} + {2'b00, inflight}) < 3'd2);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      e0       <= '0;
      e1       <= '0;
      cnt      <= 2'd0;
      inflight <= 1'b0;
    end else begin
      inflight <= ren;
      case ({push, pop})
        2'b10: begin
          if (cnt == 2'd0) e0 <= Psum_out;
          else             e1 <= Psum_out;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          e0  <= e1;
          cnt <= cnt - 2'd1;
        end
        2'b11: begin
          if (cnt == 2'd1) begin
            e0 <= Psum_out;
          end else begin
            e0 <= e1;
            e1 <= Psum_out;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/pe_stream_driver.sv
// Host driver for the conv PE: filter/IFMap loading, row markers, Psum drain.
// Optional PE_STREAM_PERF_EN adds stall_cycles/pass_cycles outputs.
module pe_stream_driver
  import pe_stream_pkg::*;
#(
  parameter int IFMAP_WIDTH          = 18,
  parameter int FILTER_WIDTH         = 8,
  parameter int FILTER_SIZE_REG_SIZE = 8,
  parameter int STRIDE_SIZE          = 3,
  parameter int ROW_LEN_SIZE         = 8,
  parameter int ROW_CNT_SIZE         = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [STRIDE_SIZE-1:0]          cfg_stride,
  input  logic [FILTER_SIZE_REG_SIZE-1:0] cfg_filter_size,
  input  logic [ROW_LEN_SIZE-1:0]         cfg_row_len,
  input  logic [ROW_CNT_SIZE-1:0]         cfg_rows,
  input  logic [IFMAP_WIDTH-3:0]          s_ifmap_data,
  input  logic                            s_ifmap_valid,
  output logic                            s_ifmap_ready,
  input  logic [FILTER_WIDTH-1:0]         s_filt_data,
  input  logic                            s_filt_valid,
  output logic                            s_filt_ready,
  output logic [IFMAP_WIDTH-3:0]          m_psum_data,
  output logic                            m_psum_valid,
  input  logic                            m_psum_ready,
  output logic                            pe_start,
  output logic [STRIDE_SIZE-1:0]          pe_stride,
  output logic [FILTER_SIZE_REG_SIZE-1:0] pe_filter_size,
  output logic [IFMAP_WIDTH-1:0]          IFMap_in,
  output logic                            wen_IFMap_buffer,
  input  logic                            ifmap_full,
  output logic [FILTER_WIDTH-1:0]         Filter_in,
  output logic                            wen_Filter_buffer,
  input  logic                            filter_full,
  output logic                            ren_Psum_buffer,
  input  logic [IFMAP_WIDTH-3:0]          Psum_out,
  input  logic                            psum_empty,
  input  logic                            pe_done,
  output logic                            busy,
  output logic                            done
`ifdef PE_STREAM_PERF_EN
  ,
  output logic [15:0]                     stall_cycles,
  output logic [15:0]                     pass_cycles
`endif
);

  state_e state;

  logic [STRIDE_SIZE-1:0]          stride_q;
  logic [FILTER_SIZE_REG_SIZE-1:0] fsize_q;
  logic [ROW_LEN_SIZE-1:0]         rowlen_q;
  logic [ROW_CNT_SIZE-1:0]         rows_q;
  logic [FILTER_SIZE_REG_SIZE-1:0] fcnt;
  logic [ROW_LEN_SIZE-1:0]         col;
  logic [ROW_CNT_SIZE-1:0]         row;
  logic                            done_seen;

  logic in_load;
  logic in_stream;
  logic f_xfer;
  logic i_xfer;
  logic sor;
  logic eor;
  logic last_f;
  logic last_row;
  logic zero_cfg;
  logic drain_en;
  logic skid_idle;

  assign in_load   = (state == LOAD_FILT);
  assign in_stream = (state == STREAM);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign pe_start  = (state == CFG);

  assign s_filt_ready  = in_load & ~filter_full;
  assign f_xfer        = s_filt_valid & s_filt_ready;
  assign s_ifmap_ready = in_stream & ~ifmap_full;
  assign i_xfer        = s_ifmap_valid & s_ifmap_ready;

  assign sor      = (col == '0);
  assign eor      = (col == rowlen_q - ROW_LEN_SIZE'(1));
  assign last_f   = (fcnt == fsize_q - FILTER_SIZE_REG_SIZE'(1));
  assign last_row = (row == rows_q - ROW_CNT_SIZE'(1));
  assign zero_cfg = (cfg_filter_size == '0) | (cfg_row_len == '0)
                  | (cfg_rows == '0);

  assign wen_Filter_buffer = f_xfer;
  assign Filter_in         = in_load ? s_filt_data : '0;
  assign wen_IFMap_buffer  = i_xfer;
  assign IFMap_in          = in_stream ? {sor, eor, s_ifmap_data} : '0;

  assign pe_stride      = busy ? stride_q : '0;
  assign pe_filter_size = busy ? fsize_q : '0;

  assign drain_en = in_stream | (state == DRAIN);

  psum_skid_buf #(
    .W (IFMAP_WIDTH-2)
  ) u_skid (
    .clk        (clk),
    .rst        (rst),
    .en         (drain_en),
    .psum_empty (psum_empty),
    .ren        (ren_Psum_buffer),
    .Psum_out   (Psum_out),
    .m_data     (m_psum_data),
    .m_valid    (m_psum_valid),
    .m_ready    (m_psum_ready),
    .idle       (skid_idle)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      stride_q  <= '0;
      fsize_q   <= '0;
      rowlen_q  <= '0;
      rows_q    <= '0;
      fcnt      <= '0;
      col       <= '0;
      row       <= '0;
      done_seen <= 1'b0;
    end else begin
      if (busy & pe_done) done_seen <= 1'b1;
      unique case (state)
        IDLE: begin
          if (start) begin
            stride_q  <= cfg_stride;
            fsize_q   <= cfg_filter_size;
            rowlen_q  <= cfg_row_len;
            rows_q    <= cfg_rows;
            fcnt      <= '0;
            col       <= '0;
            row       <= '0;
            done_seen <= 1'b0;
            state     <= zero_cfg ? DONE : CFG;
          end
        end
        CFG: state <= LOAD_FILT;
        LOAD_FILT: begin
          if (f_xfer) begin
            fcnt <= fcnt + FILTER_SIZE_REG_SIZE'(1);
            if (last_f) state <= STREAM;
          end
        end
        STREAM: begin
          if (i_xfer) begin
            if (eor) begin
              col <= '0;
              row <= row + ROW_CNT_SIZE'(1);
              if (last_row) state <= DRAIN;
            end else begin
              col <= col + ROW_LEN_SIZE'(1);
            end
          end
        end
        DRAIN: begin
          if ((done_seen | pe_done) & psum_empty & skid_idle)
            state <= DONE;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PE_STREAM_PERF_EN
  logic stall;

  assign stall = (in_load & s_filt_valid & filter_full)
               | (in_stream & s_ifmap_valid & ifmap_full);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles <= '0;
      pass_cycles  <= '0;
    end else if ((state == IDLE) & start) begin
      stall_cycles <= '0;
      pass_cycles  <= '0;
    end else begin
      if (stall & (stall_cycles != 16'hFFFF))
        stall_cycles <= stall_cycles + 16'd1;
      if (busy & (pass_cycles != 16'hFFFF))
        pass_cycles <= pass_cycles + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pe_stream_driver.sv
// Directed self-checking bench for pe_stream_driver.
// Drives host streams and a Psum buffer model; checks writes, flags, drain.
module tb_pe_stream_driver;
  import pe_stream_pkg::*;

  localparam int IW = 18;
  localparam int FW = 8;
  localparam int PW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [2:0]    cfg_stride = '0;
  logic [7:0]    cfg_filter_size = '0;
  logic [7:0]    cfg_row_len = '0;
  logic [7:0]    cfg_rows = '0;
  logic [PW-1:0] s_ifmap_data = '0;
  logic          s_ifmap_valid = 1'b0;
  logic          s_ifmap_ready;
  logic [FW-1:0] s_filt_data = '0;
  logic          s_filt_valid = 1'b0;
  logic          s_filt_ready;
  logic [PW-1:0] m_psum_data;
  logic          m_psum_valid;
  logic          m_psum_ready = 1'b0;
  logic          pe_start;
  logic [2:0]    pe_stride;
  logic [7:0]    pe_filter_size;
  logic [IW-1:0] IFMap_in;
  logic          wen_IFMap_buffer;
  logic          ifmap_full = 1'b0;
  logic [FW-1:0] Filter_in;
  logic          wen_Filter_buffer;
  logic          filter_full = 1'b0;
  logic          ren_Psum_buffer;
  logic [PW-1:0] Psum_out = '0;
  logic          psum_empty;
  logic          pe_done = 1'b0;
  logic          busy;
  logic          done;

  pe_stream_driver dut (
    .clk               (clk),
    .rst               (rst),
    .start             (start),
    .cfg_stride        (cfg_stride),
    .cfg_filter_size   (cfg_filter_size),
    .cfg_row_len       (cfg_row_len),
    .cfg_rows          (cfg_rows),
    .s_ifmap_data      (s_ifmap_data),
    .s_ifmap_valid     (s_ifmap_valid),
    .s_ifmap_ready     (s_ifmap_ready),
    .s_filt_data       (s_filt_data),
    .s_filt_valid      (s_filt_valid),
    .s_filt_ready      (s_filt_ready),
    .m_psum_data       (m_psum_data),
    .m_psum_valid      (m_psum_valid),
    .m_psum_ready      (m_psum_ready),
    .pe_start          (pe_start),
    .pe_stride         (pe_stride),
    .pe_filter_size    (pe_filter_size),
    .IFMap_in          (IFMap_in),
    .wen_IFMap_buffer  (wen_IFMap_buffer),
    .ifmap_full        (ifmap_full),
    .Filter_in         (Filter_in),
    .wen_Filter_buffer (wen_Filter_buffer),
    .filter_full       (filter_full),
    .ren_Psum_buffer   (ren_Psum_buffer),
    .Psum_out          (Psum_out),
    .psum_empty        (psum_empty),
    .pe_done           (pe_done),
    .busy              (busy),
    .done              (done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Psum buffer model: one-cycle read latency
  logic [PW-1:0] psrc [0:63];
  int pr = 0;
  int pn = 0;
  assign psum_empty = (pr >= pn);

  always @(posedge clk) begin
    if (ren_Psum_buffer) begin
      Psum_out <= psrc[pr % 64];
      pr <= pr + 1;
    end
  end

  // Monitor samples on the falling edge
  logic [IW-1:0] iq [$];
  logic [FW-1:0] fq [$];
  logic [PW-1:0] oq [$];
  int pcount = 0, dcount = 0, rens = 0, pops = 0;
  int renviol = 0, fullviol = 0;
  logic [2:0] seen_stride = '0;
  logic [7:0] seen_fsize = '0;

  always @(negedge clk) begin
    if (rst) begin
      if (wen_Filter_buffer) fq.push_back(Filter_in);
      if (wen_IFMap_buffer) iq.push_back(IFMap_in);
      if (pe_start) begin
        pcount++;
        seen_stride = pe_stride;
        seen_fsize = pe_filter_size;
      end
      if (done) dcount++;
      if (ren_Psum_buffer && (rens - pops) >= 2) renviol++;
      if (ren_Psum_buffer) rens++;
      if (m_psum_valid && m_psum_ready) begin
        oq.push_back(m_psum_data);
        pops++;
      end
      if (filter_full && (s_filt_ready || wen_Filter_buffer)) fullviol++;
    end
  end

  int f0, i0, o0, p0, d0, mid_fsize;

  task automatic run_pass(input int fs, input int rl, input int rows,
                          input int np, input bit tog, input int full_at);
    int nw;
    nw = rl * rows;
    f0 = fq.size(); i0 = iq.size(); o0 = oq.size();
    p0 = pcount; d0 = dcount; mid_fsize = -1;
    pe_done = 1'b0;
    for (int k = 0; k < np; k++) psrc[(pn + k) % 64] = PW'(k + 1);
    pn = pn + np;
    @(posedge clk); #1;
    cfg_stride = 3'd1;
    cfg_filter_size = 8'(fs);
    cfg_row_len = 8'(rl);
    cfg_rows = 8'(rows);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    s_filt_valid = 1'b1;
    s_ifmap_valid = 1'b1;
    for (int c = 0; c < 400 && dcount == d0; c++) begin
      s_filt_data = FW'(32'hA0 + fq.size() - f0);
      s_ifmap_data = PW'(32'h100 + iq.size() - i0);
      filter_full = (full_at >= 0 && c >= full_at && c < full_at + 5);
      m_psum_ready = tog ? c[0] : 1'b1;
      if (iq.size() - i0 >= nw) pe_done = 1'b1;
      if (full_at >= 0 && c == full_at + 4) mid_fsize = fq.size() - f0;
      @(posedge clk); #1;
    end
    s_filt_valid = 1'b0;
    s_ifmap_valid = 1'b0;
    filter_full = 1'b0;
    m_psum_ready = 1'b0;
    total++;
    if (dcount == d0) begin
      bad++;
      $display("FAIL pass_timeout done=%0d want=1", dcount - d0);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({busy, done, pe_start, ren_Psum_buffer} !== 4'b0) begin
      bad++;
      $display("FAIL reset_ctrl got=%b want=0000",
               {busy, done, pe_start, ren_Psum_buffer});
    end
    total++;
    if ({s_filt_ready, s_ifmap_ready, wen_Filter_buffer,
         wen_IFMap_buffer, m_psum_valid} !== 5'b0) begin
      bad++;
      $display("FAIL reset_hs got=%b want=00000",
               {s_filt_ready, s_ifmap_ready, wen_Filter_buffer,
                wen_IFMap_buffer, m_psum_valid});
    end
    total++;
    if ({IFMap_in, Filter_in, m_psum_data, pe_stride, pe_filter_size}
        !== '0) begin
      bad++;
      $display("FAIL reset_data got=%h/%h/%h want=0",
               IFMap_in, Filter_in, m_psum_data);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle busy=%b want=0", busy);
    end
  endtask

  task automatic test_basic();
    logic [IW-1:0] ex;
    run_pass(3, 4, 2, 0, 1'b0, -1);
    total++;
    if (pcount - p0 != 1) begin
      bad++;
      $display("FAIL basic_pe_start cycles=%0d want=1", pcount - p0);
    end
    total++;
    if (seen_stride !== 3'd1 || seen_fsize !== 8'd3) begin
      bad++;
      $display("FAIL basic_cfg stride=%0d fsize=%0d want=1/3",
               seen_stride, seen_fsize);
    end
    total++;
    if (fq.size() - f0 != 3) begin
      bad++;
      $display("FAIL basic_fwrites got=%0d want=3", fq.size() - f0);
    end
    for (int i = 0; i < 3 && f0 + i < fq.size(); i++) begin
      total++;
      if (fq[f0 + i] !== FW'(8'hA0 + i)) begin
        bad++;
        $display("FAIL basic_fdata[%0d] got=%h want=%h",
                 i, fq[f0 + i], 8'hA0 + i);
      end
    end
    total++;
    if (iq.size() - i0 != 8) begin
      bad++;
      $display("FAIL basic_iwrites got=%0d want=8", iq.size() - i0);
    end
    for (int i = 0; i < 8 && i0 + i < iq.size(); i++) begin
      ex = '0;
      ex[PW-1:0] = PW'(16'h100 + i);
      ex[SOR_BIT] = (i % 4 == 0);
      ex[EOR_BIT] = (i % 4 == 3);
      total++;
      if (iq[i0 + i] !== ex) begin
        bad++;
        $display("FAIL basic_iword[%0d] got=%h want=%h",
                 i, iq[i0 + i], ex);
      end
    end
    total++;
    if (dcount - d0 != 1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL basic_done count=%0d busy=%b want=1/0",
               dcount - d0, busy);
    end
  endtask

  task automatic test_filter_full();
    int fv0;
    fv0 = fullviol;
    run_pass(3, 2, 1, 0, 1'b0, 2);
    total++;
    if (fullviol != fv0) begin
      bad++;
      $display("FAIL ffull_ready viol=%0d want=0", fullviol - fv0);
    end
    total++;
    if (mid_fsize != 1) begin
      bad++;
      $display("FAIL ffull_hold writes=%0d want=1", mid_fsize);
    end
    total++;
    if (fq.size() - f0 != 3) begin
      bad++;
      $display("FAIL ffull_writes got=%0d want=3", fq.size() - f0);
    end
    for (int i = 0; i < 3 && f0 + i < fq.size(); i++) begin
      total++;
      if (fq[f0 + i] !== FW'(8'hA0 + i)) begin
        bad++;
        $display("FAIL ffull_fdata[%0d] got=%h want=%h",
                 i, fq[f0 + i], 8'hA0 + i);
      end
    end
  endtask

  task automatic test_psum();
    int rv0, r0;
    rv0 = renviol;
    r0 = rens;
    run_pass(1, 2, 1, 6, 1'b1, -1);
    total++;
    if (oq.size() - o0 != 6) begin
      bad++;
      $display("FAIL psum_count got=%0d want=6", oq.size() - o0);
    end
    for (int i = 0; i < 6 && o0 + i < oq.size(); i++) begin
      total++;
      if (oq[o0 + i] !== PW'(i + 1)) begin
        bad++;
        $display("FAIL psum_data[%0d] got=%h want=%h",
                 i, oq[o0 + i], i + 1);
      end
    end
    total++;
    if (renviol != rv0 || rens - r0 != 6) begin
      bad++;
      $display("FAIL psum_ren viol=%0d reads=%0d want=0/6",
               renviol - rv0, rens - r0);
    end
  endtask

  task automatic test_row_len1();
    run_pass(2, 1, 3, 0, 1'b0, -1);
    total++;
    if (iq.size() - i0 != 3) begin
      bad++;
      $display("FAIL rl1_writes got=%0d want=3", iq.size() - i0);
    end
    for (int i = 0; i < 3 && i0 + i < iq.size(); i++) begin
      total++;
      if (iq[i0 + i][SOR_BIT] !== 1'b1 || iq[i0 + i][EOR_BIT] !== 1'b1) begin
        bad++;
        $display("FAIL rl1_flags[%0d] got=%b%b want=11", i,
                 iq[i0 + i][SOR_BIT], iq[i0 + i][EOR_BIT]);
      end
    end
  endtask

  task automatic test_zero_rows();
    p0 = pcount;
    @(posedge clk); #1;
    cfg_filter_size = 8'd3;
    cfg_row_len = 8'd4;
    cfg_rows = 8'd0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    total++;
    if (done !== 1'b1 || pe_start !== 1'b0) begin
      bad++;
      $display("FAIL zero_done done=%b pe_start=%b want=1/0",
               done, pe_start);
    end
    @(posedge clk); #1;
    total++;
    if (done !== 1'b0 || busy !== 1'b0 || pcount != p0) begin
      bad++;
      $display("FAIL zero_idle done=%b busy=%b starts=%0d want=0/0/0",
               done, busy, pcount - p0);
    end
  endtask

  task automatic test_mid_reset();
    i0 = iq.size();
    pe_done = 1'b0;
    @(posedge clk); #1;
    cfg_filter_size = 8'd1;
    cfg_row_len = 8'd4;
    cfg_rows = 8'd4;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    s_filt_valid = 1'b1;
    s_ifmap_valid = 1'b1;
    for (int c = 0; c < 50 && iq.size() - i0 < 2; c++) begin
      @(posedge clk); #1;
    end
    total++;
    if (iq.size() - i0 < 2 || s_ifmap_ready !== 1'b1) begin
      bad++;
      $display("FAIL mrst_stream writes=%0d ready=%b want>=2/1",
               iq.size() - i0, s_ifmap_ready);
    end
    #2 rst = 1'b0;
    #1;
    total++;
    if ({busy, s_ifmap_ready, wen_IFMap_buffer, IFMap_in,
         pe_stride, pe_filter_size} !== '0) begin
      bad++;
      $display("FAIL mrst_async busy=%b ready=%b wen=%b data=%h want=0",
               busy, s_ifmap_ready, wen_IFMap_buffer, IFMap_in);
    end
    s_filt_valid = 1'b0;
    s_ifmap_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    total++;
    if (busy !== 1'b0 || s_ifmap_ready !== 1'b0) begin
      bad++;
      $display("FAIL mrst_idle busy=%b ready=%b want=0/0",
               busy, s_ifmap_ready);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_filter_full();
    test_psum();
    test_row_len1();
    test_zero_rows();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pe_stream_driver.md
Name: pe_stream_driver

Overview:
- Host-side driver for the convolution PE.
- Takes the host's IFMap and filter streams (valid/ready) and writes them into the PE's IFMap and filter buffers, inserting row markers and respecting buffer-full back-pressure.
- Reads partial sums out of the PE's Psum buffer into a valid/ready output stream.
- Sequences one layer pass: configure, load filter, stream rows, drain.

Parameters:
- IFMAP_WIDTH, 18, PE IFMap word width = {sor, eor, data[IFMAP_WIDTH-3:0]}.
- FILTER_WIDTH, 8, filter word width.
- FILTER_SIZE_REG_SIZE, 8, filter_size width.
- STRIDE_SIZE, 3, stride width.
- ROW_LEN_SIZE, 8, row-length counter width.
- ROW_CNT_SIZE, 8, row-count counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- start  in  1  one-cycle start pulse; ignored unless IDLE.
- cfg_stride  in  STRIDE_SIZE  latched on start.
- cfg_filter_size  in  FILTER_SIZE_REG_SIZE  filter words to load; latched on start.
- cfg_row_len  in  ROW_LEN_SIZE  IFMap words per row; latched on start.
- cfg_rows  in  ROW_CNT_SIZE  rows per pass; latched on start.
- s_ifmap_data  in  IFMAP_WIDTH-2  host IFMap data.
- s_ifmap_valid  in  1  host IFMap valid.
- s_ifmap_ready  out  1  host IFMap ready.
- s_filt_data  in  FILTER_WIDTH  host filter data.
- s_filt_valid  in  1  host filter valid.
- s_filt_ready  out  1  host filter ready.
- m_psum_data  out  IFMAP_WIDTH-2  output psum data.
- m_psum_valid  out  1  output psum valid.
- m_psum_ready  in  1  output psum ready.
- pe_start  out  1  start pulse to PE.
- pe_stride  out  STRIDE_SIZE  stride to PE.
- pe_filter_size  out  FILTER_SIZE_REG_SIZE  filter size to PE.
- IFMap_in  out  IFMAP_WIDTH  IFMap buffer write data.
- wen_IFMap_buffer  out  1  IFMap buffer write enable.
- ifmap_full  in  1  IFMap buffer full.
- Filter_in  out  FILTER_WIDTH  filter buffer write data.
- wen_Filter_buffer  out  1  filter buffer write enable.
- filter_full  in  1  filter buffer full.
- ren_Psum_buffer  out  1  Psum buffer read enable.
- Psum_out  in  IFMAP_WIDTH-2  Psum buffer read data; valid 1 cycle after ren.
- psum_empty  in  1  Psum buffer empty.
- pe_done  in  1  PE finished the pass.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse on entering DONE.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, counters 0, skid buffer empty.
- FSM states: IDLE -> CFG -> LOAD_FILT -> STREAM -> DRAIN -> DONE -> IDLE.
- IDLE:
  - start latches the four cfg inputs and moves to CFG.
  - start with cfg_filter_size==0, cfg_row_len==0 or cfg_rows==0 goes straight to DONE, with no PE activity.
- CFG:
  - One cycle; pe_start=1.
  - pe_stride/pe_filter_size show the latched values and hold them until IDLE.
- LOAD_FILT:
  - s_filt_ready = ~filter_full.
  - On s_filt_valid & s_filt_ready: wen_Filter_buffer=1, Filter_in=s_filt_data, fcnt++.
  - When fcnt reaches filter_size-1 with a transfer, go to STREAM.
  - All outputs are combinational from current state and inputs; zero latency.
- STREAM:
  - s_ifmap_ready = ~ifmap_full.
  - On transfer: wen_IFMap_buffer=1 and IFMap_in={sor, eor, data}.
  - sor=1 when col==0; eor=1 when col==row_len-1. row_len==1 gives sor=eor=1.
  - col wraps to 0 at eor and increments row.
  - After eor of row rows-1, go to DRAIN.
- Psum drain, active in STREAM and DRAIN:
  - ren_Psum_buffer = ~psum_empty & (skid occupancy + reads in flight < 2).
  - Psum_out is captured into a 2-entry skid 1 cycle after ren.
  - m_psum_* is driven from the skid head. No data loss or duplication under any m_psum_ready pattern.
- DRAIN: move to DONE when pe_done has been seen (sticky) & psum_empty & skid empty & no read in flight.
- DONE: done=1 for one cycle, then IDLE.
- Outside LOAD_FILT/STREAM, s_*_ready=0 and the write enables are 0.
- Reset mid-pass: everything clears immediately; the host must restart.

Optional Feature:
- Macro: PE_STREAM_PERF_EN.
- Defined:
  - Adds output stall_cycles[15:0], a saturating count of cycles in LOAD_FILT/STREAM with valid=1 and buffer full.
  - Adds output pass_cycles[15:0], a saturating count from CFG to DONE.
  - Both clear on start.
- Undefined: the ports and logic are absent.

Decomposition:
- Package pe_stream_pkg holds the state enum typedef (IDLE, CFG, LOAD_FILT, STREAM, DRAIN, DONE) and the IFMap flag bit-index constants (SOR_BIT = IFMAP_WIDTH-1, EOR_BIT = IFMAP_WIDTH-2).
- One sub-module: psum_skid_buf, a 2-entry read-latency skid buffer with an in-flight tracker.

Test Plan:
- filter_size=3, row_len=4, rows=2, stride=1, no back-pressure:
  - pe_start exactly 1 cycle.
  - 3 filter writes.
  - 8 IFMap writes with flags (sor,eor) = 10,00,00,01 per row.
  - done once.
- filter_full asserted for 5 cycles mid-load: s_filt_ready=0 in those cycles, no write, fcnt holds; 3 writes total afterwards.
- Psum_out = 0x0001..0x0006 with m_psum_ready toggling 1/0: m_psum_data shows 1..6 in order with no duplicates; ren never issued with 2 entries held.
- row_len=1, rows=3: every IFMap write has sor=eor=1.
- start with cfg_rows=0: DONE next cycle with no pe_start. Also, rst low during STREAM: all outputs 0 asynchronously, then IDLE.
